// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage data memory responder.
//   Executes loads and stores over a word-addressed RAM with RV32I byte/half/word access
//   and sign/zero extension, after a fixed multi-cycle latency.
//   Optional macro DMEM_ALIGN_CHECK_EN: flags misaligned half/word accesses, suppressing the
//   write and returning zero. Without it, misaligned accesses are force-aligned.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_read, mem_write request strobes from the control unit (held while stall=1)
//   funct3              000 B, 001 H, 010 W, 100 BU, 101 HU (others act as word)
//   addr, wdata         byte address and store data
//   rdata               registered load result, held until the next access executes
//   stall               high while a request is in progress
//   misaligned          one-cycle error pulse in the DONE cycle
module data_mem_unit #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CntLast = CW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic [31:0]   mem [DEPTH];

  logic          req, exec, do_write, mis_acc;
  logic          is_byte, is_half;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wd_lanes, rd_word, ld_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Upper address bits are ignored so addresses wrap modulo DEPTH*4.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign req   = mem_read | mem_write;
  // Gated by rst so the pipeline is released as soon as reset asserts.
  assign stall = req & (state_q != StDone) & ~rst;
  assign idx   = addr[AW+1:2];

  // Next-state logic; exec marks the edge on which the access is performed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (cnt_q == CntLast) begin
          exec    = 1'b1;
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Access size decode, store lane steering and load extraction.
  always_comb begin
    is_byte  = (funct3[1:0] == 2'b00);
    is_half  = (funct3[1:0] == 2'b01);
    rd_word  = mem[idx];
    ld_byte  = rd_word[8*addr[1:0] +: 8];
    ld_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];
`ifdef DMEM_ALIGN_CHECK_EN
    mis_acc  = (is_half & addr[0]) | (~is_byte & ~is_half & (addr[1:0] != 2'b00));
`else
    mis_acc  = 1'b0;
`endif
    if (is_byte) begin
      be       = 4'b0001 << addr[1:0];
      wd_lanes = {4{wdata[7:0]}};
      ld_val   = {{24{~funct3[2] & ld_byte[7]}}, ld_byte};
    end else if (is_half) begin
      be       = addr[1] ? 4'b1100 : 4'b0011;
      wd_lanes = {2{wdata[15:0]}};
      ld_val   = {{16{~funct3[2] & ld_half[15]}}, ld_half};
    end else begin
      be       = 4'b1111;
      wd_lanes = wdata;
      ld_val   = rd_word;
    end
    do_write = exec & mem_write & ~mis_acc;
    rdata_d  = rdata_q;
    if (exec) begin
      if (mis_acc) begin
        rdata_d = '0;
      end else if (!mem_write) begin
        rdata_d = ld_val;
      end
    end
    mis_d = exec & mis_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // RAM is not reset; exec can only fire from StBusy, which reset clears.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
        end
      end
    end
  end

  assign rdata      = rdata_q;
  assign misaligned = mis_q;

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-memory responder that executes the load/store commands issued by the control unit (mem_read / mem_write) in the MEM stage.
- Holds a word-addressed RAM and performs byte/half/word accesses with RV32I sign/zero extension.
- Multi-cycle access latency; the unit holds the pipeline off with a stall handshake.
- rdata feeds the mem_to_reg write-back mux.

Parameters:
- DEPTH, 1024, number of 32-bit words (power of two)
- LATENCY, 2, BUSY cycles per access (>=1)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- mem_read  input  1  load request (from control unit)
- mem_write  input  1  store request (from control unit)
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address (ALU result)
- wdata  input  32  store data (rs2)
- rdata  output  32  load result, extended to 32 bits
- stall  output  1  high while the access is in progress; pipeline freezes
- misaligned  output  1  one-cycle error pulse (see Optional Feature)

Behaviour:
- req = mem_read | mem_write. The requester holds addr, wdata, funct3, mem_read and mem_write stable while stall=1.
- Reset (async): state=IDLE, cnt=0, rdata=0, misaligned=0. RAM contents are not reset.
- stall = req & (state != DONE), combinational.
- FSM:
  - IDLE: on req, go to BUSY with cnt=0; otherwise stay in IDLE.
  - BUSY: cnt increments each cycle. When cnt==LATENCY-1, the access executes on that clock edge and the FSM goes to DONE.
  - DONE: stall=0, rdata/misaligned valid for exactly this cycle; go to IDLE next.
- Latency: a request first seen in IDLE produces LATENCY+1 stall cycles, then one DONE cycle. Back-to-back requests cost one IDLE cycle between them.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Store:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes addr[1]*2 +1:+0 with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged.
- Load:
  - LB/LH select the lane(s) and sign-extend.
  - LBU/LHU zero-extend.
  - LW returns the full word.
  - rdata is registered at the execute edge and held until the next access executes.
- Stores leave rdata unchanged.
- Both mem_read and mem_write set: treated as a store; rdata unchanged.
- funct3 011/110/111 (undefined): treated as word size.
- Request dropped mid-BUSY (protocol violation): the access still completes as captured. Inputs are sampled at the execute edge.
- Reset asserted mid-BUSY: returns to IDLE with no RAM write. A write already executed stays committed.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Half access with addr[0]=1, or word/undefined-size access with addr[1:0]!=0, is misaligned.
  - A misaligned access takes the same FSM timing, performs no RAM write, sets rdata=0, and pulses misaligned=1 in DONE.
- Not defined:
  - misaligned is tied to 0.
  - Misaligned accesses are force-aligned: half uses addr[1] only, word ignores addr[1:0].

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> stall high for 3 cycles per access (LATENCY=2); rdata=0xDEADBEEF in DONE.
- After the above, SB addr=0x11 wdata=0x80, then LB 0x11 -> rdata=0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- SH addr=0x22 wdata=0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LH 0x20 -> old low half unchanged.
- Wrap: SW addr=DEPTH*4+0x4 data=0x12345678, then LW 0x4 -> 0x12345678.
- With DMEM_ALIGN_CHECK_EN: SW addr=0x13 -> misaligned=1 for one cycle, LW 0x10 unchanged. Without the macro: SW 0x13 writes word 0x10.
- Reset asserted during BUSY of an SW to 0x30 (cnt=0) -> stall=0 immediately, state IDLE, later LW 0x30 returns the prior contents.
